display_scheduler: RTL

Time-multiplexes the board's three 7-segment digits between four 32-bit value sources, such as processor registers or the ALU result. It round-robins over the enabled sources with a programmable dwell time, and supports hold and manual-select overrides. It converts the selected value to BCD with a sequential shift-add-3 (double-dabble) engine instead of divide/modulo logic, then drives the active-low 21-bit segment bus. It sits between the processor datapath and the board display pins.

---
 rtl/display_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: round-robins four 32-bit sources onto three
// active-low 7-segment digits through a sequential double-dabble converter.
module display_scheduler #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] src_vals,
    input  logic [3:0]   src_valid,
    input  logic         hold,
    input  logic         manual_en,
    input  logic [1:0]   manual_sel,
    output logic [20:0]  seven_Segs,
    output logic [1:0]   src_idx,
    output logic         busy,
    output logic         ovf
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DTERM = DW'(DWELL_CYCLES - 1);
    localparam logic [20:0] BLANK = 21'h1FFFFF;
    localparam logic [20:0] DASHES = {3{7'b0111111}};

    typedef enum logic [2:0] {
        SELECT,
        LOAD,
        SHIFT,
        UPDATE,
        DWELL
    } state_t;

    state_t        state;
    logic [1:0]    last;
    logic [1:0]    sel;
    logic [9:0]    val;
    logic          ovf_pend;
    logic [11:0]   bcd;
    logic [3:0]    cnt;
    logic [DW-1:0] dcnt;

    logic          found;
    logic [1:0]    nxt;
    logic [1:0]    cand;
    logic [11:0]   adj;
    logic [31:0]   cur;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0011000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // Next enabled source after last; nearest offset wins
    always_comb begin
        found = 1'b0;
        nxt   = last;
        cand  = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (src_valid[cand]) begin
                found = 1'b1;
                nxt   = cand;
            end
        end
    end

    // Selected source word and add-3 correction of each BCD nibble
    always_comb begin
        cur = src_vals[{sel, 5'd0} +: 32];
        adj = bcd;
        for (int d = 0; d < 3; d++) begin
            if (bcd[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    // Scheduler FSM with conversion engine and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SELECT;
            last       <= 2'd3;
            sel        <= '0;
            val        <= '0;
            ovf_pend   <= 1'b0;
            bcd        <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            seven_Segs <= BLANK;
            src_idx    <= '0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            unique case (state)
                SELECT: begin
                    if (manual_en) begin
                        sel   <= manual_sel;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else if (found) begin
                        sel   <= nxt;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        seven_Segs <= BLANK;
                        ovf        <= 1'b0;
                    end
                end
                LOAD: begin
                    val      <= cur[9:0];
                    ovf_pend <= (cur > 32'd999);
                    bcd      <= '0;
                    cnt      <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {bcd, val} <= {adj[10:0], val, 1'b0};
                    cnt        <= cnt + 4'd1;
                    if (cnt == 4'd9)
                        state <= UPDATE;
                end
                UPDATE: begin
                    seven_Segs <= ovf_pend ? DASHES :
                                  {seg(bcd[11:8]), seg(bcd[7:4]), seg(bcd[3:0])};
                    src_idx    <= sel;
                    ovf        <= ovf_pend;
                    last       <= sel;
                    busy       <= 1'b0;
                    dcnt       <= '0;
                    state      <= DWELL;
                end
                DWELL: begin
                    if (manual_en && manual_sel != src_idx) begin
                        dcnt  <= '0;
                        state <= SELECT;
                    end else if (!hold) begin
                        if (dcnt == DTERM) begin
                            dcnt  <= '0;
                            state <= SELECT;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end
endmodule
